wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued writeback entries (power of 2, 2..16).
REQ-002 SHALL take address width `ASIZE and data width `DSIZE from define.v.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mem_valid/mem_ready/mem_addr/mem_data  in/out/in/in  1/1/`ASIZE/`DSIZE  load-result write request.
REQ-006 SHALL have ports alu_valid/alu_ready/alu_addr/alu_data  in/out/in/in  1/1/`ASIZE/`DSIZE  ALU-result write request.
REQ-007 SHALL have port hold  input  1  blocks draining to the register file.
REQ-008 SHALL have ports wen/waddr/wdata  output  1/`ASIZE/`DSIZE  register-file write port.
REQ-009 SHALL have ports chk_addr  input  `ASIZE and chk_hit  output  1  hazard query against queued entries.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 SHALL accept a request on a source when its valid and ready are both 1 at a rising clk edge; at most one accept per cycle.
REQ-012 SHALL give mem fixed priority: mem_ready = !full; alu_ready = !full && !mem_valid.
REQ-013 SHALL compute full from current occupancy only; a same-cycle pop SHALL NOT free a slot for a push.
REQ-014 SHALL accept but not enqueue requests with address 0 (write to R0 dropped; count unchanged).
REQ-015 SHALL store accepted entries in FIFO order in a circular buffer; pointers wrap modulo DEPTH.
REQ-016 SHALL drive wen = (count != 0) && !hold, with waddr/wdata = head entry; head popped at the same edge.
REQ-017 SHALL, when count = 0 or hold = 1, drive wen = 0 and waddr/wdata = 0 (bypass case per REQ-024).
REQ-018 SHALL on simultaneous push and pop keep count unchanged and preserve ordering.
REQ-019 SHALL give an entry accepted at edge N with an empty queue and hold = 0 a write at edge N+1 (wen high during cycle N+1).
REQ-020 SHALL assert chk_hit combinationally when chk_addr != 0 and matches the address of any queued entry; chk_hit = 0 when empty.
REQ-021 SHALL, when hold is asserted, retain all entries and keep accepting until full.

Reset
REQ-022 SHALL, on rst low, immediately clear pointers and count, discard all queued entries, and force wen = 0, waddr = 0, wdata = 0, chk_hit = 0, count = 0; ready outputs = 1 while rst is high and the queue is empty.
REQ-023 SHALL resume accepting at the first rising edge after rst deasserts; an accept in flight at assertion is lost.

Configuration
REQ-024 SHALL, when WB_BYPASS_EN is defined, pass an accepted request straight to wen/waddr/wdata in the same cycle when count = 0, hold = 0 and address != 0, without enqueueing (zero latency); count and chk_hit are then unaffected by it.
REQ-025 SHALL, when WB_BYPASS_EN is undefined, route every write through the FIFO (minimum latency one cycle per REQ-019).

Verification
REQ-026 SHALL cover: empty queue, alu push addr 3 data 0x0A -> next cycle wen=1, waddr=3, wdata=0x0A; count returns to 0.
REQ-027 SHALL cover: mem_valid and alu_valid both 1 (addr 5 / addr 6) -> alu_ready=0, mem entry (5) written first, then alu entry (6).
REQ-028 SHALL cover: hold=1, push 4 entries with DEPTH=4 -> count=4, both readies 0; release hold -> 4 writes in order, one per cycle.
REQ-029 SHALL cover: push addr 0 data 0xFF -> accepted, count stays 0, wen never 1; chk_addr=0 -> chk_hit=0.
REQ-030 SHALL cover: 2 entries queued (addr 7, 9), assert rst low mid-drain -> wen=0 and count=0 immediately, neither remaining write occurs after release.
REQ-031 SHALL cover (WB_BYPASS_EN defined): empty queue, push addr 2 data 0x11 -> wen=1, waddr=2, wdata=0x11 in the same cycle, count stays 0.

Source files
------------

// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - writeback queue request/drain/hazard-query bundle
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

interface wb_queue_if #(
    parameter int DEPTH = 4
);
    logic                     mem_valid;
    logic                     mem_ready;
    logic [`ASIZE-1:0]        mem_addr;
    logic [`DSIZE-1:0]        mem_data;
    logic                     alu_valid;
    logic                     alu_ready;
    logic [`ASIZE-1:0]        alu_addr;
    logic [`DSIZE-1:0]        alu_data;
    logic                     hold;
    logic                     wen;
    logic [`ASIZE-1:0]        waddr;
    logic [`DSIZE-1:0]        wdata;
    logic [`ASIZE-1:0]        chk_addr;
    logic                     chk_hit;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  hold, chk_addr,
        output mem_ready, alu_ready, wen, waddr, wdata, chk_hit, count
    );

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output hold, chk_addr,
        input  mem_ready, alu_ready, wen, waddr, wdata, chk_hit, count
    );
endinterface

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - register-file writeback FIFO, optional zero-latency bypass under WB_BYPASS_EN
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_queue_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [`ASIZE-1:0] addr_q [DEPTH];
    logic [`DSIZE-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              full;
    logic              acc;
    logic              push;
    logic              pop;
    logic              byp;
    logic [`ASIZE-1:0] in_addr;
    logic [`DSIZE-1:0] in_data;
    logic [PW-1:0]     off;
    logic              hit;

    // Arbitration (mem wins), accept/drop/bypass decisions, drain port and next pointers
    always_comb begin
        full          = (count_q == CW'(DEPTH));
        bus.mem_ready = !full;
        bus.alu_ready = !full && !bus.mem_valid;
        acc           = (bus.mem_valid && !full) || (bus.alu_valid && !full && !bus.mem_valid);
        in_addr       = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
        in_data       = bus.mem_valid ? bus.mem_data : bus.alu_data;
        pop           = (count_q != '0) && !bus.hold;
`ifdef WB_BYPASS_EN
        byp           = acc && (count_q == '0) && !bus.hold && (in_addr != '0);
`else
        byp           = 1'b0;
`endif
        // R0 writes are accepted for flow control but never stored
        push          = acc && (in_addr != '0) && !byp;

        bus.wen   = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        if (pop) begin
            bus.wen   = 1'b1;
            bus.waddr = addr_q[rd_ptr_q];
            bus.wdata = data_q[rd_ptr_q];
        end else if (byp) begin
            bus.wen   = 1'b1;
            bus.waddr = in_addr;
            bus.wdata = in_data;
        end

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        bus.count = count_q;
    end

    // Hazard query: a slot is live when its distance from the head is below the occupancy
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (addr_q[i] == bus.chk_addr) && (bus.chk_addr != '0)) begin
                hit = 1'b1;
            end
        end
        bus.chk_hit = hit;
    end

    // Pointer and occupancy registers; reset empties the queue at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful inside the live window
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue against a queue-based reference
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

module tb_wb_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [`ASIZE-1:0] maddr [$];
    logic [`DSIZE-1:0] mdata [$];

    wb_queue_if #(.DEPTH(DEPTH)) bus ();

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic mv, input int ma, input int md,
                        input logic av, input int aa, input int ad,
                        input logic h, input int ca);
        logic full, e_mr, e_ar, acc, byp, pop, e_wen, hit;
        logic [`ASIZE-1:0] a_addr, e_wa, c_addr, m_a, l_a;
        logic [`DSIZE-1:0] a_data, e_wd, m_d, l_d;
        m_a = ma[`ASIZE-1:0];
        m_d = md[`DSIZE-1:0];
        l_a = aa[`ASIZE-1:0];
        l_d = ad[`DSIZE-1:0];
        c_addr = ca[`ASIZE-1:0];
        bus.mem_valid = mv;
        bus.mem_addr  = m_a;
        bus.mem_data  = m_d;
        bus.alu_valid = av;
        bus.alu_addr  = l_a;
        bus.alu_data  = l_d;
        bus.hold      = h;
        bus.chk_addr  = c_addr;
        #2;
        full   = (maddr.size() == DEPTH);
        e_mr   = !full;
        e_ar   = !full && !mv;
        acc    = (mv && e_mr) || (av && e_ar);
        a_addr = mv ? m_a : l_a;
        a_data = mv ? m_d : l_d;
        byp    = 1'b0;
`ifdef WB_BYPASS_EN
        byp    = acc && (maddr.size() == 0) && !h && (a_addr != 0);
`endif
        pop    = (maddr.size() != 0) && !h;
        e_wen  = pop || byp;
        e_wa   = pop ? maddr[0] : (byp ? a_addr : '0);
        e_wd   = pop ? mdata[0] : (byp ? a_data : '0);
        hit    = 1'b0;
        foreach (maddr[i]) if (c_addr != 0 && maddr[i] == c_addr) hit = 1'b1;
        chk("mem_ready", bus.mem_ready, e_mr);
        chk("alu_ready", bus.alu_ready, e_ar);
        chk("wen",       bus.wen,       e_wen);
        chk("waddr",     bus.waddr,     e_wa);
        chk("wdata",     bus.wdata,     e_wd);
        chk("chk_hit",   bus.chk_hit,   hit);
        chk("count",     bus.count,     maddr.size());
        @(posedge clk);
        if (pop) begin
            void'(maddr.pop_front());
            void'(mdata.pop_front());
        end
        if (acc && a_addr != 0 && !byp) begin
            maddr.push_back(a_addr);
            mdata.push_back(a_data);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.hold = 0; bus.chk_addr = 0;
        #3;
        chk("rst_wen",   bus.wen,     1'b0);
        chk("rst_count", bus.count,   0);
        chk("rst_waddr", bus.waddr,   0);
        chk("rst_wdata", bus.wdata,   0);
        chk("rst_hit",   bus.chk_hit, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // single alu write, one-cycle latency (or zero with bypass)
        step(0, 0, 0, 1, 3, 'h0A, 0, 3);
        idle(2);
        chk("single_drained", bus.count, 0);

        // mem beats alu; alu retried next cycle
        step(1, 5, 'h55, 1, 6, 'h66, 0, 0);
        step(0, 0, 0, 1, 6, 'h66, 0, 5);
        idle(3);

        // fill under hold, fifth attempt refused, then ordered drain
        step(0, 0, 0, 1, 1, 'h101, 1, 0);
        step(1, 2, 'h102, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 3, 'h103, 1, 2);
        step(1, 4, 'h104, 0, 0, 0, 1, 4);
        step(1, 8, 'h108, 1, 9, 'h109, 1, 8);
        chk("full_count", bus.count, DEPTH);
        idle(6);

        // R0 write dropped; zero query never hits
        step(1, 0, 'hFF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // hazard hits against held entries, reset in the middle of the drain
        step(0, 0, 0, 1, 7, 'h77, 1, 7);
        step(0, 0, 0, 1, 9, 'h99, 1, 7);
        step(0, 0, 0, 0, 0, 0, 1, 8);
        step(0, 0, 0, 0, 0, 0, 0, 9);
        bus.chk_addr = 9;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_wen",   bus.wen,     1'b0);
        chk("midrst_count", bus.count,   0);
        chk("midrst_hit",   bus.chk_hit, 1'b0);
        maddr.delete();
        mdata.delete();
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7));
        end
        idle(DEPTH + 2);
        chk("final_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
